// File: rtl/pwm_pkg.sv
// Shared PWM definitions: capture FSM states and default widths, common to
// the PWM generator and the PWM capture block.
package pwm_pkg;

    localparam int unsigned PWM_CNT_W    = 16;
    localparam int unsigned PWM_FILT_LEN = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } pwm_state_e;

endpackage

// File: rtl/pwm_capture_if.sv
// Signal bundle around a PWM capture block: the PWM source side (master)
// drives enable and the pad, the capture side (slave) returns measurements.
interface pwm_capture_if
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W = PWM_CNT_W
);
    logic             en;
    logic             pwm;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high;
    logic             valid;
    logic             timeout;
    logic             level;

    modport master (
        output en, pwm,
        input  period, high, valid, timeout, level
    );

    modport slave (
        input  en, pwm,
        output period, high, valid, timeout, level
    );
endinterface

// File: rtl/pwm_sync_filter.sv
// Two-flop synchronizer for the PWM pad with an optional glitch filter,
// compiled in by defining PWM_CAPTURE_GLITCH_FILTER_EN.
module pwm_sync_filter
    import pwm_pkg::*;
#(
    parameter int unsigned FILT_LEN = PWM_FILT_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic sync_p0;
    logic sync_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= d;
            sync_p1 <= sync_p0;
        end
    end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    // Stage p2: the output follows sync_p1 only after FILT_LEN consecutive
    // samples disagree with it, so shorter pulses never reach q.
    localparam int unsigned RUN_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic [RUN_W-1:0] run_p2;
    logic             filt_p2;

    always_ff @(posedge clk) begin
        if (rst) begin
            run_p2  <= '0;
            filt_p2 <= 1'b0;
        end else if (sync_p1 == filt_p2) begin
            run_p2 <= '0;
        end else if (run_p2 == RUN_W'(FILT_LEN - 1)) begin
            run_p2  <= '0;
            filt_p2 <= sync_p1;
        end else begin
            run_p2 <= run_p2 + RUN_W'(1);
        end
    end

    assign q = filt_p2;
`else
    // The window length is irrelevant without the filter; a zero window is not a valid build.
    if (FILT_LEN >= 1) begin : g_direct
        assign q = sync_p1;
    end
`endif

endmodule

// File: rtl/pwm_capture.sv
// PWM period / high-time capture. Glitch filter on the input is optional:
// define PWM_CAPTURE_GLITCH_FILTER_EN to compile it in.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W    = PWM_CNT_W,
    parameter int unsigned FILT_LEN = PWM_FILT_LEN
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             en_i,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] high_o,
    output logic             valid_o,
    output logic             timeout_o,
    output logic             level_o
);
    logic             s;
    logic             s_d;
    logic             rise;
    logic             fall;
    pwm_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hi_cnt;

    function automatic logic cnt_saturated(input logic [CNT_W-1:0] c);
        return &c;
    endfunction

    pwm_sync_filter #(
        .FILT_LEN (FILT_LEN)
    ) u_sync (
        .clk (wb_clk_i),
        .rst (wb_rst_i),
        .d   (pwm_in),
        .q   (s)
    );

    // Both edges come from the same delayed level, so the sync/filter latency cancels out.
    assign rise    = s & ~s_d;
    assign fall    = ~s & s_d;
    assign level_o = s;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            s_d       <= 1'b0;
            state     <= IDLE;
            cnt       <= '0;
            hi_cnt    <= '0;
            period_o  <= '0;
            high_o    <= '0;
            valid_o   <= 1'b0;
            timeout_o <= 1'b0;
        end else begin
            s_d     <= s;
            valid_o <= 1'b0;
            if (!en_i) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (rise) begin
                            state     <= HIGH;
                            cnt       <= CNT_W'(1);
                            timeout_o <= 1'b0;
                        end
                    end
                    HIGH: begin
                        if (cnt_saturated(cnt)) begin
                            state     <= IDLE;
                            cnt       <= '0;
                            timeout_o <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                            if (fall) begin
                                hi_cnt <= cnt;
                                state  <= LOW;
                            end
                        end
                    end
                    LOW: begin
                        // A rise closes the period even when the counter is saturated.
                        if (rise) begin
                            period_o <= cnt;
                            high_o   <= hi_cnt;
                            valid_o  <= 1'b1;
                            state    <= HIGH;
                            cnt      <= CNT_W'(1);
                        end else if (cnt_saturated(cnt)) begin
                            state     <= IDLE;
                            cnt       <= '0;
                            timeout_o <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule
